// File: rtl/dmem_line_backend.sv
`default_nettype none
// dmem_line_backend: fixed-latency 256-bit line store serving data-cache refills and write-backs.
// Optional macro DMEM_RANGE_CHECK_EN adds err_o and neutralises accesses beyond DEPTH lines.
module dmem_line_backend #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_LO = 5;
  localparam int IDX_HI = IDX_LO + IDX_W - 1;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] counter;
  logic             req_write;
  logic [IDX_W-1:0] req_idx;
  logic [LINE_W-1:0] req_data;
  logic             req_bad;
  logic             range_bad;
  logic             accept;
  logic             finish;

  logic [LINE_W-1:0] mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
  logic unused_addr;
  assign range_bad   = |addr_i[ADDR_W-1:IDX_HI+1];
  assign unused_addr = ^addr_i[IDX_LO-1:0];
`else
  logic unused_addr;
  assign range_bad   = 1'b0;
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_HI+1], addr_i[IDX_LO-1:0]};
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable_i) state_nxt = S_BUSY;
      S_BUSY:  if (counter == CNT_LAST) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o  = (state == S_ACK);
    busy_o = (state != S_IDLE);
    accept = (state == S_IDLE) && enable_i;
    finish = (state == S_BUSY) && (counter == CNT_LAST);
  end

  // The request is captured once at acceptance; later input activity is ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      counter   <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
      req_bad   <= 1'b0;
    end else if (accept) begin
      counter   <= CNT_W'(1);
      req_write <= write_i;
      req_idx   <= addr_i[IDX_HI:IDX_LO];
      req_data  <= data_i;
      req_bad   <= range_bad;
    end else if (state == S_BUSY) begin
      counter   <= counter + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= '0;
    end else if (finish && !req_write) begin
      data_o <= req_bad ? '0 : mem[req_idx];
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 err_o <= 1'b0;
    else if (finish && req_bad) err_o <= 1'b1;
  end
`endif

  // Storage survives reset; a reset-aborted request never reaches finish, so it never writes.
  always_ff @(posedge clk_i) begin
    if (finish && req_write && !req_bad) mem[req_idx] <= req_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_backend.sv
`default_nettype none
// Randomized and directed bench for dmem_line_backend with a line-level reference model.
module tb_dmem_line_backend;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;
`ifdef DMEM_RANGE_CHECK_EN
  logic         err_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] mem_m [512];
  bit           known [512];
  logic [255:0] exp_dout;
  logic         exp_err;

  always #5 clk = ~clk;

  dmem_line_backend #(
    .LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o),
    .busy_o(busy_o)
`ifdef DMEM_RANGE_CHECK_EN
    , .err_o(err_o)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag);
`ifdef DMEM_RANGE_CHECK_EN
    chk(tag, {255'd0, err_o}, {255'd0, exp_err});
`endif
  endtask

  // mode 0: normal; 1: disturb inputs while busy; 2: hold enable through ack; 3: reset mid-request
  task automatic run_req(input bit wr, input logic [31:0] a, input logic [255:0] wd, input int mode);
    logic [8:0] idx;
    bit         bad;
    idx = a[13:5];
`ifdef DMEM_RANGE_CHECK_EN
    bad = (a[31:14] != 18'd0);
`else
    bad = 1'b0;
`endif
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = a;
    data_i   = wd;
    @(posedge clk); #1;
    for (int k = 0; k <= LAT; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("ack_busy_k%0d", k), {254'd0, ack_o, busy_o}, {254'd0, (k == LAT), 1'b1});
      if (mode == 1) begin
        if (k == 2) begin
          addr_i  = 32'h0000_00C0;
          data_i  = {8{$urandom}};
          write_i = ~wr;
        end
        if (k == 3) enable_i = 1'b0;
        if (k == 4) enable_i = 1'b1;
      end
      if (mode == 3 && k == 5) begin
        rst_i = 1'b0;
        #1;
        exp_dout = '0;
        exp_err  = 1'b0;
        chk("rst_abort_ack_busy", {254'd0, ack_o, busy_o}, 256'd0);
        chk("rst_abort_data", data_o, exp_dout);
        chk_err("rst_abort_err");
        enable_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        return;
      end
    end
    if (wr) begin
      if (!bad) begin
        mem_m[idx] = wd;
        known[idx] = 1'b1;
      end
    end else begin
      exp_dout = bad ? 256'd0 : mem_m[idx];
    end
    if (bad) exp_err = 1'b1;
    chk(wr ? "data_after_write" : "read_data", data_o, exp_dout);
    chk_err("err_at_ack");
    if (mode != 2) enable_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_ack", {254'd0, ack_o, busy_o}, 256'd0);
    if (mode == 1) begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        chk("no_extra_request", {254'd0, ack_o, busy_o}, 256'd0);
      end
    end
  endtask

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] old_100;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    exp_dout = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < 512; i++) known[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack_busy", {254'd0, ack_o, busy_o}, 256'd0);
    chk("reset_data", data_o, 256'd0);
    chk_err("reset_err");
    rst_i = 1'b1;
    @(posedge clk); #1;

    run_req(1'b1, 32'h0000_0000, {32{8'hAA}}, 0);
    run_req(1'b0, 32'h0000_0000, {8{$urandom}}, 0);

    run_req(1'b1, 32'h0000_0040, {4{64'h0123_4567_89AB_CDEF}}, 0);
    run_req(1'b0, 32'h0000_005F, '0, 0);

    line_a = {8{$urandom}};
    line_b = ~line_a;
    run_req(1'b1, 32'h0000_0080, line_a, 0);
    run_req(1'b1, 32'h0000_00C0, line_b, 0);
    run_req(1'b0, 32'h0000_0080, '0, 1);

    old_100 = {8{$urandom}};
    run_req(1'b1, 32'h0000_0100, old_100, 0);
    run_req(1'b1, 32'h0000_0100, {32{8'h55}}, 3);
    run_req(1'b0, 32'h0000_0100, '0, 0);

    run_req(1'b0, 32'h0000_0040, '0, 2);
    run_req(1'b0, 32'h0000_0000, '0, 0);

`ifdef DMEM_RANGE_CHECK_EN
    run_req(1'b1, 32'h0000_4000, {8{$urandom}}, 0);
    run_req(1'b0, 32'h0000_0000, '0, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      logic [8:0]  idx;
      logic [17:0] upper;
      logic [4:0]  off;
      bit          wr;
      idx = 9'($urandom_range(0, 15) * 31);
      off = 5'($urandom);
`ifdef DMEM_RANGE_CHECK_EN
      upper = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(1, 262143)) : 18'd0;
      wr = ($urandom_range(0, 1) == 1) || (!known[idx] && upper == 18'd0);
`else
      upper = 18'($urandom);
      wr = ($urandom_range(0, 1) == 1) || !known[idx];
`endif
      run_req(wr, {upper, idx, off}, {8{$urandom}}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
